// File: rtl/img_pkg.sv
// img_pkg: shared image-geometry defaults and helpers for the window pipeline.
package img_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int IMG_W_DEF = 1920;
  localparam int IMG_H_DEF = 1080;
  function automatic int clog2_safe(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/line_ram.sv
// line_ram: 1R1W synchronous RAM, read-before-write on address collision.
module line_ram import img_pkg::*; #(
  parameter int DEPTH = IMG_W_DEF,
  parameter int WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [clog2_safe(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         re,
  input  logic [clog2_safe(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]             rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/window_buffer_kxk.sv
// window_buffer_kxk: KxK sliding window over a raster stream, K-1 lines held in one RAM.
module window_buffer_kxk import img_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int K      = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           in_pixel,
  input  logic                        in_valid,
  input  logic                        in_sof,
  output logic                        out_valid,
  output logic [K*K*DATA_W-1:0]       out_window,
  output logic [$clog2(IMG_W)-1:0]    out_col,
  output logic [$clog2(IMG_H)-1:0]    out_row,
  output logic                        out_eol,
  output logic                        out_eof
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int HALF = (K - 1) / 2;
  localparam int LW = (K - 1) * DATA_W;
  logic [CW-1:0] col, cur_col, col1;
  logic [RW-1:0] row, cur_row, row1;
  logic [DATA_W-1:0] pix1;
  logic v1, col_end, row_end, win_ok, src_eol, src_eof;
  logic [LW-1:0] rd_word, wr_word;
  logic [K*DATA_W-1:0] tap;
  logic [DATA_W-1:0] win [K][K];
  always_comb begin
    cur_col = in_sof ? '0 : col;
    cur_row = in_sof ? '0 : row;
    col_end = cur_col == CW'(IMG_W - 1);
    row_end = cur_row == RW'(IMG_H - 1);
    tap = {rd_word, pix1};
    wr_word = {rd_word[(K-2)*DATA_W-1:0], pix1};
    win_ok = v1 && col1 >= CW'(K - 1) && row1 >= RW'(K - 1);
    src_eol = col1 == CW'(IMG_W - 1);
    src_eof = src_eol && row1 == RW'(IMG_H - 1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      col <= col_end ? '0 : cur_col + 1'b1;
      row <= col_end ? (row_end ? '0 : cur_row + 1'b1) : cur_row;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      v1 <= 1'b0;
      pix1 <= '0;
      col1 <= '0;
      row1 <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        pix1 <= in_pixel;
        col1 <= cur_col;
        row1 <= cur_row;
      end
    end
  // The word written back one cycle after the read pushes the column down by one line.
  line_ram #(.DEPTH(IMG_W), .WIDTH(LW)) u_ram (
    .clk   (clk),
    .we    (v1),
    .waddr (col1),
    .wdata (wr_word),
    .re    (in_valid),
    .raddr (cur_col),
    .rdata (rd_word)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          win[i][j] <= '0;
    end else if (v1) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++)
          win[i][j] <= win[i][j+1];
        win[i][K-1] <= tap[(K-1-i)*DATA_W +: DATA_W];
      end
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_valid <= 1'b0;
      out_eol <= 1'b0;
      out_eof <= 1'b0;
      out_col <= '0;
      out_row <= '0;
    end else begin
      out_valid <= win_ok;
      out_eol <= win_ok && src_eol;
      out_eof <= win_ok && src_eof;
      if (win_ok) begin
        out_col <= col1 - CW'(HALF);
        out_row <= row1 - RW'(HALF);
      end
    end
  for (genvar r = 0; r < K; r++) begin : g_r
    for (genvar c = 0; c < K; c++) begin : g_c
      assign out_window[(r*K+c)*DATA_W +: DATA_W] = win[r][c];
    end
  end
endmodule

// File: tb/tb_window_buffer_kxk.sv
// tb_window_buffer_kxk: scoreboard bench driving a K=3 and a K=5 instance with the same stream.
module tb_window_buffer_kxk;
  localparam int W = 8;
  localparam int H = 6;
  typedef struct packed {
    logic [199:0] win;
    logic [2:0]   col;
    logic [2:0]   row;
    logic         eol;
    logic         eof;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  logic [7:0] in_pixel = '0;
  logic v3, l3, f3, v5, l5, f5;
  logic [71:0] w3;
  logic [199:0] w5;
  logic [2:0] c3, r3, c5, r5;
  exp_t q3[$];
  exp_t q5[$];
  int n_chk = 0;
  int n_fail = 0;
  logic ok_d1 [2] = '{1'b0, 1'b0};
  logic ok_d2 [2] = '{1'b0, 1'b0};
  int nv [2] = '{0, 0};
  int nl [2] = '{0, 0};
  int nf [2] = '{0, 0};
  logic [199:0] mid [2];
  logic [7:0] img [H][W];
  int mr = 0;
  int mc = 0;

  always #5 clk = ~clk;

  window_buffer_kxk #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .K(3)) dut3 (
    .clk(clk), .reset(reset), .in_pixel(in_pixel), .in_valid(in_valid), .in_sof(in_sof),
    .out_valid(v3), .out_window(w3), .out_col(c3), .out_row(r3), .out_eol(l3), .out_eof(f3)
  );
  window_buffer_kxk #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .K(5)) dut5 (
    .clk(clk), .reset(reset), .in_pixel(in_pixel), .in_valid(in_valid), .in_sof(in_sof),
    .out_valid(v5), .out_window(w5), .out_col(c5), .out_row(r5), .out_eol(l5), .out_eof(f5)
  );

  function automatic int kof(input int k);
    return k ? 5 : 3;
  endfunction

  function automatic logic [199:0] build(input int k, input logic [7:0] base);
    logic [199:0] v = '0;
    for (int r = 0; r < kof(k); r++)
      for (int c = 0; c < kof(k); c++)
        v[(r*kof(k)+c)*8 +: 8] = 8'(base + r*16 + c);
    return v;
  endfunction

  task automatic mon(input int k, input logic v, input logic [199:0] w, input logic [2:0] c,
                     input logic [2:0] r, input logic l, input logic f);
    exp_t e;
    int kk = kof(k);
    n_chk++;
    if (v !== ok_d2[k] || (!v && (l || f))) begin
      n_fail++;
      $display("FAIL valid K=%0d: got v=%b eol=%b eof=%b, need v=%b", kk, v, l, f, ok_d2[k]);
    end
    if (v) begin
      n_chk++;
      if ((k == 0 ? q3.size() : q5.size()) == 0) begin
        n_fail++;
        $display("FAIL window K=%0d: unexpected output row=%0d col=%0d", kk, r, c);
      end else begin
        if (k == 0) e = q3.pop_front(); else e = q5.pop_front();
        if ({w, c, r, l, f} !== e) begin
          n_fail++;
          $display("FAIL window K=%0d: got r=%0d c=%0d eol=%b eof=%b win=%h, need r=%0d c=%0d eol=%b eof=%b win=%h",
                   kk, r, c, l, f, w, e.row, e.col, e.eol, e.eof, e.win);
        end
      end
      nv[k]++;
      nl[k] += int'(l);
      nf[k] += int'(f);
      if (int'(r) == kk / 2 && int'(c) == kk / 2) mid[k] = w;
    end
  endtask

  always @(negedge clk)
    if (!reset) begin
      mon(0, v3, {128'b0, w3}, c3, r3, l3, f3);
      mon(1, v5, w5, c5, r5, l5, f5);
    end

  task automatic cyc(input logic v, input logic sof, input logic [7:0] pix);
    exp_t e;
    int kk;
    in_valid = v;
    in_sof = sof;
    in_pixel = pix;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      ok_d2[k] = ok_d1[k];
      ok_d1[k] = 1'b0;
    end
    if (v) begin
      if (sof) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = pix;
      for (int k = 0; k < 2; k++) begin
        kk = kof(k);
        if (mr >= kk - 1 && mc >= kk - 1) begin
          ok_d1[k] = 1'b1;
          e = '0;
          for (int r = 0; r < kk; r++)
            for (int c = 0; c < kk; c++)
              e.win[(r*kk+c)*8 +: 8] = img[mr-kk+1+r][mc-kk+1+c];
          e.col = 3'(mc - kk / 2);
          e.row = 3'(mr - kk / 2);
          e.eol = (mc == W - 1);
          e.eof = (mc == W - 1) && (mr == H - 1);
          if (k == 0) q3.push_back(e); else q5.push_back(e);
        end
      end
      if (mc == W - 1) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end else mc++;
    end
    #1;
  endtask

  task automatic px(input logic [7:0] base, input logic sof, input logic gaps);
    int r, c;
    if (gaps)
      for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) cyc(1'b0, 1'b0, 8'h00);
    r = sof ? 0 : mr;
    c = sof ? 0 : mc;
    cyc(1'b1, sof, 8'(base + r*16 + c));
  endtask

  task automatic chk_counts(input int a3, input int b3, input int e3, input int a5, input int b5, input int e5);
    repeat (4) cyc(1'b0, 1'b0, 8'h00);
    n_chk++;
    if (nv[0] != a3 || nl[0] != b3 || nf[0] != e3) begin
      n_fail++;
      $display("FAIL counts K=3: got valid=%0d eol=%0d eof=%0d, need %0d/%0d/%0d", nv[0], nl[0], nf[0], a3, b3, e3);
    end
    n_chk++;
    if (nv[1] != a5 || nl[1] != b5 || nf[1] != e5) begin
      n_fail++;
      $display("FAIL counts K=5: got valid=%0d eol=%0d eof=%0d, need %0d/%0d/%0d", nv[1], nl[1], nf[1], a5, b5, e5);
    end
    nv = '{0, 0};
    nl = '{0, 0};
    nf = '{0, 0};
  endtask

  task automatic chk_win(input int k, input logic [199:0] need, input string name);
    n_chk++;
    if (mid[k] !== need) begin
      n_fail++;
      $display("FAIL %s: got %h, need %h", name, mid[k], need);
    end
  endtask

  task automatic chk_zero(input string name);
    n_chk++;
    if ({v3, w3, c3, r3, l3, f3} !== '0) begin
      n_fail++;
      $display("FAIL %s K=3: got v=%b r=%0d c=%0d eol=%b eof=%b win=%h, need all 0", name, v3, r3, c3, l3, f3, w3);
    end
    n_chk++;
    if ({v5, w5, c5, r5, l5, f5} !== '0) begin
      n_fail++;
      $display("FAIL %s K=5: got v=%b r=%0d c=%0d eol=%b eof=%b win=%h, need all 0", name, v5, r5, c5, l5, f5, w5);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_sof = 1'b0;
    reset = 1'b1;
    #1;
    chk_zero("async_reset");
    q3.delete();
    q5.delete();
    ok_d1 = '{1'b0, 1'b0};
    ok_d2 = '{1'b0, 1'b0};
    nv = '{0, 0};
    nl = '{0, 0};
    nf = '{0, 0};
    mr = 0;
    mc = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_state");
    reset = 1'b0;
    for (int i = 0; i < W * H; i++) px(8'h00, i == 0, 1'b0);
    chk_counts(24, 4, 1, 8, 2, 1);
    chk_win(0, 200'h22_21_20_12_11_10_02_01_00, "first_window_k3");
    chk_win(1, build(1, 8'h00), "first_window_k5");
    for (int i = 0; i < W * H; i++) px(8'h00, i == 0, 1'b1);
    for (int i = 0; i < W * H; i++) px(8'h80, 1'b0, 1'b0);
    chk_counts(48, 8, 2, 16, 4, 2);
    chk_win(0, 200'hA2_A1_A0_92_91_90_82_81_80, "frame2_window_k3");
    chk_win(1, build(1, 8'h80), "frame2_window_k5");
    for (int i = 0; i < 3 * W + 4; i++) px(8'h00, i == 0, 1'b0);
    for (int i = 0; i < W * H; i++) px(8'h40, i == 0, 1'b0);
    chk_counts(32, 5, 1, 8, 2, 1);
    chk_win(0, build(0, 8'h40), "sof_window_k3");
    chk_win(1, build(1, 8'h40), "sof_window_k5");
    for (int i = 0; i < 3 * W + 5; i++) px(8'h00, i == 0, 1'b0);
    do_reset();
    for (int i = 0; i < W * H; i++) px(8'h20, 1'b0, 1'b0);
    chk_counts(24, 4, 1, 8, 2, 1);
    chk_win(0, build(0, 8'h20), "post_reset_window_k3");
    chk_win(1, build(1, 8'h20), "post_reset_window_k5");
    n_chk++;
    if (q3.size() != 0 || q5.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending windows, need 0/0", q3.size(), q5.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
